backlight_frame_scheduler: RTL and testbench

BACKLIGHT_FRAME_SCHEDULER -- requirements
Module: backlight_frame_scheduler

---
 rtl/backlight_frame_scheduler.sv | 109 ++++++++++
 tb/tb_backlight_frame_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/backlight_frame_scheduler.sv
// backlight_frame_scheduler: streams one frame of zone averages, scaled by a latched
// ambient gain or replaced by a test pattern, into the LED driver's back buffer.
module backlight_frame_scheduler #(
    parameter int ZONES = 360
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_frame_done,
    input  logic [1:0] I_mode,
    input  logic [7:0] I_bright,
    output logic [8:0] O_zone_raddr,
    input  logic [7:0] I_zone_rdata,
    output logic       O_wr_en,
    input  logic       I_drv_ready,
    output logic [8:0] O_wr_addr,
    output logic [7:0] O_wr_data,
    output logic       O_swap,
    output logic       O_busy,
    output logic [7:0] O_drop_cnt
);
    typedef enum logic [2:0] {IDLE, LATCH, RD, CALC, WR, SWAP} state_t;
    state_t      state_q;
    logic [1:0]  mode_q;
    logic [8:0]  gain_q, idx_q, raddr_q, waddr_q, gain_sum, gain_d;
    logic [7:0]  wdata_q, drop_q, scaled, calc_d;
    logic        pending_q, wr_en_q, swap_q, busy_q, in_frame;
    logic [16:0] prod;
    assign gain_sum = 9'd64 + {1'b0, I_bright};
    assign gain_d   = gain_sum > 9'd256 ? 9'd256 : gain_sum;
    assign prod     = {9'd0, I_zone_rdata} * {8'd0, gain_q};
    assign scaled   = 8'(prod >> 8);
    // Checker pattern lights even zones and darkens odd ones.
    assign calc_d   = mode_q == 2'd0 ? scaled :
                      mode_q == 2'd1 ? 8'hff :
                      mode_q == 2'd2 ? {8{~idx_q[0]}} : I_zone_rdata;
    assign in_frame = state_q inside {LATCH, RD, CALC, WR};
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            gain_q    <= '0;
            idx_q     <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            drop_q    <= '0;
            pending_q <= 1'b0;
            wr_en_q   <= 1'b0;
            swap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // A frame arriving mid-transfer is queued once; further ones are lost.
            if (in_frame && I_frame_done) begin
                if (pending_q) drop_q <= drop_q + {7'd0, drop_q != 8'hff};
                else pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (I_frame_done) begin
                    state_q <= LATCH;
                    busy_q  <= 1'b1;
                end
                LATCH: begin
                    mode_q  <= I_mode;
                    gain_q  <= gain_d;
                    idx_q   <= '0;
                    state_q <= RD;
                end
                RD: begin
                    raddr_q <= idx_q;
                    state_q <= CALC;
                end
                CALC: begin
                    wdata_q <= calc_d;
                    waddr_q <= idx_q;
                    wr_en_q <= 1'b1;
                    state_q <= WR;
                end
                WR: if (I_drv_ready) begin
                    wr_en_q <= 1'b0;
                    if (idx_q == 9'(ZONES - 1)) begin
                        swap_q  <= 1'b1;
                        state_q <= SWAP;
                    end else begin
                        idx_q   <= idx_q + 9'd1;
                        state_q <= RD;
                    end
                end
                SWAP: begin
                    swap_q <= 1'b0;
                    if (pending_q || I_frame_done) begin
                        pending_q <= 1'b0;
                        state_q   <= LATCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign O_zone_raddr = raddr_q;
    assign O_wr_en      = wr_en_q;
    assign O_wr_addr    = waddr_q;
    assign O_wr_data    = wdata_q;
    assign O_swap       = swap_q;
    assign O_busy       = busy_q;
    assign O_drop_cnt   = drop_q;
endmodule

// File: tb/tb_backlight_frame_scheduler.sv
// tb_backlight_frame_scheduler: scoreboard bench; expected zone writes are queued when a
// frame is launched and matched against every accepted driver write.
module tb_backlight_frame_scheduler;
    localparam int ZONES = 360;
    typedef struct packed {logic [8:0] a; logic [7:0] d;} exp_t;
    logic       clk = 1'b0, rst = 1'b1, frame_done = 1'b0, drv_ready = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [7:0] bright = 8'd0, zone_rdata, wr_data, drop_cnt;
    logic [8:0] zone_raddr, wr_addr;
    logic       wr_en, swap, busy;
    logic [7:0] mem [0:511];
    exp_t       q[$];
    int         n_cmp = 0, n_bad = 0, cyc = 0, swaps = 0, exp_swaps = 0;
    int         t0 = 0, first_xfer = -1, swap_edge = -1;

    backlight_frame_scheduler #(.ZONES(ZONES)) dut (
        .I_clk(clk), .I_rst(rst), .I_frame_done(frame_done), .I_mode(mode),
        .I_bright(bright), .O_zone_raddr(zone_raddr), .I_zone_rdata(zone_rdata),
        .O_wr_en(wr_en), .I_drv_ready(drv_ready), .O_wr_addr(wr_addr),
        .O_wr_data(wr_data), .O_swap(swap), .O_busy(busy), .O_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign zone_rdata = mem[zone_raddr];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model(input int md, input int br, input int i, input int z);
        int g;
        g = 64 + br;
        if (g > 256) g = 256;
        case (md)
            0: return (z * g) >> 8;
            1: return 255;
            2: return (i % 2 == 0) ? 255 : 0;
            default: return z;
        endcase
    endfunction

    // Negedge monitor: a write seen valid with ready is accepted at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && wr_en && drv_ready) begin
            if (q.size() == 0) chk("unexpected_wr_addr", int'(wr_addr), -1);
            else begin
                e = q.pop_front();
                chk("wr_addr", int'(wr_addr), int'(e.a));
                chk("wr_data", int'(wr_data), int'(e.d));
                if (e.a == 9'd0) first_xfer = cyc + 1;
            end
        end
        if (swap) begin
            swaps++;
            swap_edge = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int md, input int br);
        exp_t e;
        for (int i = 0; i < ZONES; i++) begin
            e.a = 9'(i);
            e.d = 8'(model(md, br, i, int'(mem[i])));
            q.push_back(e);
        end
    endtask

    // Launch a frame, then scramble mode/bright once LATCH has sampled them.
    task automatic run_frame(input int md, input int br);
        mode = 2'(md);
        bright = 8'(br);
        push_frame(md, br);
        frame_done = 1'b1;
        t0 = cyc + 1;
        step();
        frame_done = 1'b0;
        step();
        mode = 2'($urandom_range(0, 3));
        bright = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, int'(busy), 0);
        chk({tag, "_queue_left"}, q.size(), 0);
    endtask

    task automatic wait_raddr(input int a);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (zone_raddr != 9'(a) && n < 5000);
        chk("wait_raddr_timeout", int'(zone_raddr), a);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 512; i++) mem[i] = (v < 0) ? 8'($urandom_range(0, 255)) : 8'(v);
    endtask

    initial begin
        int sw;
        exp_t e;
        fill(200);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_raddr", int'(zone_raddr), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_swap", int'(swap), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(drop_cnt), 0);

        run_frame(0, 0);
        exp_swaps++;
        wait_idle("scaled_dark");
        chk("first_xfer_edge", first_xfer, t0 + 4);
        chk("swap_edge", swap_edge, t0 + 1081);

        run_frame(0, 255);
        exp_swaps++;
        wait_idle("scaled_bright");
        fill(-1);
        run_frame(0, 192);
        exp_swaps++;
        wait_idle("gain_boundary");
        run_frame(0, $urandom_range(0, 191));
        exp_swaps++;
        wait_idle("scaled_random");
        fill(37);
        run_frame(3, 0);
        exp_swaps++;
        wait_idle("bypass");
        fill(-1);
        run_frame(2, 10);
        exp_swaps++;
        wait_idle("checker");

        run_frame(1, 0);
        exp_swaps++;
        wait_raddr(5);
        drv_ready = 1'b0;
        e = q[0];
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_wr_en", int'(wr_en), 1);
            chk("bp_wr_addr", int'(wr_addr), 5);
            chk("bp_wr_data", int'(wr_data), int'(e.d));
        end
        drv_ready = 1'b1;
        wait_idle("full_on_bp");

        // Mode change plus three frame pulses mid-frame: current frame stays scaled.
        fill(-1);
        run_frame(0, 40);
        exp_swaps += 2;
        wait_raddr(50);
        mode = 2'd1;
        push_frame(1, 0);
        repeat (3) begin
            frame_done = 1'b1;
            step();
            frame_done = 1'b0;
            step();
        end
        chk("drop_two", int'(drop_cnt), 2);
        sw = 0;
        while (!swap && sw < 5000) begin
            step();
            sw++;
        end
        chk("swap_seen", int'(swap), 1);
        step();
        chk("no_idle_gap_busy", int'(busy), 1);
        wait_idle("back_to_back");
        chk("drop_after", int'(drop_cnt), 2);

        run_frame(0, 128);
        wait_raddr(100);
        step();
        chk("at_idx100", int'(wr_addr), 100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        chk("mrst_raddr", int'(zone_raddr), 0);
        chk("mrst_wr_en", int'(wr_en), 0);
        chk("mrst_wr_addr", int'(wr_addr), 0);
        chk("mrst_wr_data", int'(wr_data), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_drop", int'(drop_cnt), 0);
        sw = swaps;
        repeat (40) step();
        chk("mrst_no_swap", swaps, sw);
        run_frame(2, 0);
        exp_swaps++;
        wait_idle("restart");

        chk("swap_count", swaps, exp_swaps);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
